mem_arbiter: RTL and testbench

- Sequences the single shared MemoryController between two requesters: instruction-fetch refill and the load/store port.
- Data requests have priority by default. A bounded starvation counter forces an instruction grant after STARVE_LIMIT consecutive data grants.
- Handles pipeline flush (rob_clear): in-flight loads and fetches are aborted; a store already issued always completes.

---
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one MemoryController between the instruction-fetch refill port and
// the load/store port. Data requests win by default; a saturating starvation
// counter forces an instruction grant once STARVE_LIMIT consecutive data
// grants have been made while a fetch was waiting. A pipeline flush
// (rob_clear) aborts in-flight fetches and loads, but an issued store always
// runs to completion because its side effect cannot be undone.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              global enable; low freezes every register
//   rob_clear           pipeline flush
//   inst_valid/addr     fetch request (held until inst_ready)
//   inst_ready/res      one-cycle completion pulse + fetched word
//   data_valid/wr/size/addr/value
//                       load/store request (held until data_ready)
//   data_ready/res      one-cycle completion pulse + load result
//   mc_valid/wr/addr/len/data
//                       request to the MemoryController (registered)
//   mc_abort            one-cycle pulse: controller drops the current op
//   mc_ready/res        controller completion pulse + result
//
// Optional feature (macro MEM_ARB_PERF_EN): adds 32-bit wrapping counters
// perf_inst_grants, perf_data_grants and perf_starve_forced.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        inst_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_res,
    input  logic        data_valid,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_value,
    output logic        data_ready,
    output logic [31:0] data_res,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_data,
    output logic        mc_abort,
    input  logic        mc_ready,
    input  logic [31:0] mc_res
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_inst_grants,
    output logic [31:0] perf_data_grants,
    output logic [31:0] perf_starve_forced
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_d, wr_d;
    logic [31:0]      addr_d, data_d;
    logic [2:0]       len_d;
    logic             grant_inst, grant_data, grant_forced;
    logic             active;

    // Results come straight from the controller; the ready pulses qualify them.
    assign inst_res = mc_res;
    assign data_res = mc_res;

    // Nothing may advance (or pulse) while disabled or while in reset.
    assign active = rdy_in && !rst_in;

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = mc_valid;
        wr_d         = mc_wr;
        addr_d       = mc_addr;
        len_d        = mc_len;
        data_d       = mc_data;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        grant_forced = 1'b0;
        inst_ready   = 1'b0;
        data_ready   = 1'b0;
        mc_abort     = 1'b0;

        if (active) begin
            unique case (state_q)
                IDLE: begin
                    if (rob_clear) begin
                        cnt_d = '0;
                    end else if (cnt_q == LIMIT && inst_valid) begin
                        grant_inst   = 1'b1;
                        grant_forced = 1'b1;
                        cnt_d        = '0;
                    end else if (data_valid) begin
                        grant_data = 1'b1;
                        // Count only data grants that made a fetch wait.
                        if (!inst_valid)
                            cnt_d = '0;
                        else if (cnt_q >= LIMIT)
                            cnt_d = LIMIT;
                        else
                            cnt_d = cnt_q + 1'b1;
                    end else if (inst_valid) begin
                        grant_inst = 1'b1;
                        cnt_d      = '0;
                    end
                end

                BUSY_I: begin
                    // Flush beats a coincident completion: the result is dropped.
                    if (rob_clear) begin
                        mc_abort = 1'b1;
                        valid_d  = 1'b0;
                        state_d  = IDLE;
                    end else if (mc_ready) begin
                        inst_ready = 1'b1;
                        valid_d    = 1'b0;
                        state_d    = IDLE;
                    end
                end

                BUSY_D: begin
                    // A store already in the controller is never aborted.
                    if (rob_clear && !mc_wr) begin
                        mc_abort = 1'b1;
                        valid_d  = 1'b0;
                        state_d  = IDLE;
                    end else if (mc_ready) begin
                        data_ready = 1'b1;
                        valid_d    = 1'b0;
                        state_d    = IDLE;
                    end
                end

                default: begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            endcase

            if (grant_inst) begin
                state_d = BUSY_I;
                valid_d = 1'b1;
                wr_d    = 1'b0;
                addr_d  = inst_addr;
                len_d   = 3'b010;
                data_d  = '0;
            end else if (grant_data) begin
                state_d = BUSY_D;
                valid_d = 1'b1;
                wr_d    = data_wr;
                addr_d  = data_addr;
                len_d   = data_size;
                data_d  = data_value;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mc_valid <= 1'b0;
            mc_wr    <= 1'b0;
            mc_addr  <= '0;
            mc_len   <= '0;
            mc_data  <= '0;
        end else begin
            // When rdy_in is low every *_d equals its register, so this holds.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_valid <= valid_d;
            mc_wr    <= wr_d;
            mc_addr  <= addr_d;
            mc_len   <= len_d;
            mc_data  <= data_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Grant strobes are already gated by rdy_in, so the counters freeze too.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_inst_grants   <= '0;
            perf_data_grants   <= '0;
            perf_starve_forced <= '0;
        end else begin
            if (grant_inst)
                perf_inst_grants <= perf_inst_grants + 32'd1;
            if (grant_data)
                perf_data_grants <= perf_data_grants + 32'd1;
            if (grant_forced)
                perf_starve_forced <= perf_starve_forced + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (STARVE_LIMIT = 4). The MemoryController is
// played by the stimulus itself: mc_ready/mc_res are driven at chosen cycles.
// Inputs change 2 time units after a rising edge and outputs are sampled
// 1 time unit later, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_res;
    logic        data_valid;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_value;
    logic        data_ready;
    logic [31:0] data_res;
    logic        mc_valid;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_data;
    logic        mc_abort;
    logic        mc_ready;
    logic [31:0] mc_res;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_inst_grants;
    logic [31:0] perf_data_grants;
    logic [31:0] perf_starve_forced;
`endif

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .inst_valid (inst_valid),
        .inst_addr  (inst_addr),
        .inst_ready (inst_ready),
        .inst_res   (inst_res),
        .data_valid (data_valid),
        .data_wr    (data_wr),
        .data_size  (data_size),
        .data_addr  (data_addr),
        .data_value (data_value),
        .data_ready (data_ready),
        .data_res   (data_res),
        .mc_valid   (mc_valid),
        .mc_wr      (mc_wr),
        .mc_addr    (mc_addr),
        .mc_len     (mc_len),
        .mc_data    (mc_data),
        .mc_abort   (mc_abort),
        .mc_ready   (mc_ready),
        .mc_res     (mc_res)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_inst_grants   (perf_inst_grants),
        .perf_data_grants   (perf_data_grants),
        .perf_starve_forced (perf_starve_forced)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Safety net: the directed sequence is a few hundred cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 2 time units past the rising edge.
    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    // Expected grant order for the starvation run: 1 = fetch, 0 = load.
    logic is_inst [7];
    int   dcount;

    initial begin
        is_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
        inst_valid = 1'b0; inst_addr = '0;
        data_valid = 1'b0; data_wr = 1'b0; data_size = '0;
        data_addr = '0; data_value = '0;
        mc_ready = 1'b0; mc_res = '0;

        // ---------------- reset state ----------------
        step(); step();
        mc_ready = 1'b1; rob_clear = 1'b1; #1;
        check("rst_mc_valid",   mc_valid,   1'b0);
        check("rst_mc_wr",      mc_wr,      1'b0);
        check("rst_mc_addr",    mc_addr,    32'h0);
        check("rst_mc_len",     mc_len,     3'd0);
        check("rst_mc_data",    mc_data,    32'h0);
        check("rst_mc_abort",   mc_abort,   1'b0);
        check("rst_inst_ready", inst_ready, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        mc_ready = 1'b0; rob_clear = 1'b0;

        // ---------------- single fetch ----------------
        rst_in = 1'b0; inst_valid = 1'b1; inst_addr = 32'h100;
        step();
        check("f1_mc_valid", mc_valid, 1'b1);
        check("f1_mc_addr",  mc_addr,  32'h100);
        check("f1_mc_len",   mc_len,   3'b010);
        check("f1_mc_wr",    mc_wr,    1'b0);
        check("f1_mc_data",  mc_data,  32'h0);
        step();
        check("f1_wait_ready", inst_ready, 1'b0);
        step(); step();
        mc_ready = 1'b1; mc_res = 32'hDEADBEEF; #1;
        check("f1_inst_ready", inst_ready, 1'b1);
        check("f1_inst_res",   inst_res,   32'hDEADBEEF);
        check("f1_data_ready", data_ready, 1'b0);
        step();
        mc_ready = 1'b0; inst_valid = 1'b0; #1;
        check("f1_ready_drop", inst_ready, 1'b0);
        check("f1_valid_drop", mc_valid,   1'b0);
        step();
        check("f1_no_regrant", mc_valid, 1'b0);

        // ---------------- simultaneous requests ----------------
        inst_valid = 1'b1; inst_addr = 32'h400;
        data_valid = 1'b1; data_wr = 1'b0; data_size = 3'd0; data_addr = 32'h200;
        step();
        check("sim_d_valid", mc_valid, 1'b1);
        check("sim_d_addr",  mc_addr,  32'h200);
        check("sim_d_len",   mc_len,   3'd0);
        check("sim_d_wr",    mc_wr,    1'b0);
        mc_ready = 1'b1; mc_res = 32'h55; #1;
        check("sim_data_ready", data_ready, 1'b1);
        check("sim_data_res",   data_res,   32'h55);
        check("sim_no_iready",  inst_ready, 1'b0);
        step();
        mc_ready = 1'b0; data_valid = 1'b0; #1;
        check("sim_idle_gap", mc_valid, 1'b0);
        step();
        check("sim_i_valid", mc_valid, 1'b1);
        check("sim_i_addr",  mc_addr,  32'h400);
        check("sim_i_len",   mc_len,   3'b010);
        mc_ready = 1'b1; mc_res = 32'h77; #1;
        check("sim_inst_ready", inst_ready, 1'b1);
        check("sim_inst_res",   inst_res,   32'h77);
        step();
        mc_ready = 1'b0; inst_valid = 1'b0;

        // ---------------- starvation: 6 loads vs. a waiting fetch ----------------
        inst_valid = 1'b1; inst_addr = 32'h800;
        data_valid = 1'b1; data_size = 3'd2; data_addr = 32'h1000;
        dcount = 0;
        for (int g = 0; g < 7; g++) begin
            step();
            check("stv_valid", mc_valid, 1'b1);
            if (is_inst[g]) begin
                check("stv_i_addr", mc_addr, 32'h800);
                mc_ready = 1'b1; mc_res = 32'(g); #1;
                check("stv_i_ready", inst_ready, 1'b1);
                check("stv_i_no_dready", data_ready, 1'b0);
            end else begin
                check("stv_d_addr", mc_addr, 32'h1000 + 32'(4 * dcount));
                mc_ready = 1'b1; mc_res = 32'(g); #1;
                check("stv_d_ready", data_ready, 1'b1);
                check("stv_d_no_iready", inst_ready, 1'b0);
            end
            step();
            mc_ready = 1'b0;
            if (is_inst[g]) begin
                inst_valid = 1'b0;
            end else begin
                dcount++;
                if (dcount == 6) data_valid = 1'b0;
                else data_addr = 32'h1000 + 32'(4 * dcount);
            end
            #1;
            check("stv_gap", mc_valid, 1'b0);
        end

        // ---------------- flush during load ----------------
        data_valid = 1'b1; data_wr = 1'b0; data_size = 3'b110; data_addr = 32'h2000;
        step();
        check("fl_valid", mc_valid, 1'b1);
        check("fl_len",   mc_len,   3'b110);
        check("fl_addr",  mc_addr,  32'h2000);
        step();
        check("fl_no_early_abort", mc_abort, 1'b0);
        step();
        rob_clear = 1'b1; mc_ready = 1'b1; #1;
        check("fl_abort",    mc_abort,   1'b1);
        check("fl_no_ready", data_ready, 1'b0);
        step();
        mc_ready = 1'b0; data_valid = 1'b0;
        inst_valid = 1'b1; inst_addr = 32'h300; #1;
        check("fl_valid_drop",  mc_valid, 1'b0);
        check("fl_abort_pulse", mc_abort, 1'b0);
        step();
        rob_clear = 1'b0; #1;
        check("fl_idle_clear_no_grant", mc_valid, 1'b0);
        step();
        check("fl_fetch_valid", mc_valid, 1'b1);
        check("fl_fetch_addr",  mc_addr,  32'h300);
        check("fl_fetch_len",   mc_len,   3'b010);
        mc_ready = 1'b1; mc_res = 32'h9; #1;
        check("fl_fetch_ready", inst_ready, 1'b1);
        step();
        mc_ready = 1'b0; inst_valid = 1'b0;

        // ---------------- flush during store ----------------
        data_valid = 1'b1; data_wr = 1'b1; data_size = 3'd2;
        data_addr = 32'h30000; data_value = 32'h41;
        step();
        check("st_valid", mc_valid, 1'b1);
        check("st_wr",    mc_wr,    1'b1);
        check("st_addr",  mc_addr,  32'h30000);
        check("st_data",  mc_data,  32'h41);
        step();
        rob_clear = 1'b1; #1;
        check("st_no_abort", mc_abort, 1'b0);
        step();
        check("st_valid_held", mc_valid, 1'b1);
        mc_ready = 1'b1; #1;
        check("st_data_ready",  data_ready, 1'b1);
        check("st_no_abort_rd", mc_abort,   1'b0);
        step();
        rob_clear = 1'b0; mc_ready = 1'b0; data_valid = 1'b0; data_wr = 1'b0; #1;
        check("st_done_idle", mc_valid, 1'b0);

        // ---------------- rdy_in low ----------------
        rdy_in = 1'b0; inst_valid = 1'b1; inst_addr = 32'h500;
        step();
        check("rdy_idle_frozen", mc_valid, 1'b0);
        rdy_in = 1'b1;
        step();
        check("rdy_grant_valid", mc_valid, 1'b1);
        check("rdy_grant_addr",  mc_addr,  32'h500);
        rdy_in = 1'b0; mc_ready = 1'b1; mc_res = 32'h1234; #1;
        check("rdy_low_ready0", inst_ready, 1'b0);
        step();
        check("rdy_low_ready1", inst_ready, 1'b0);
        check("rdy_low_valid1", mc_valid,   1'b1);
        step();
        check("rdy_low_ready2", inst_ready, 1'b0);
        step();
        rdy_in = 1'b1; mc_ready = 1'b0; #1;
        check("rdy_held_valid", mc_valid,   1'b1);
        check("rdy_held_ready", inst_ready, 1'b0);
        step();
        mc_ready = 1'b1; mc_res = 32'hCAFE; #1;
        check("rdy_late_ready", inst_ready, 1'b1);
        check("rdy_late_res",   inst_res,   32'hCAFE);
        step();
        mc_ready = 1'b0; inst_valid = 1'b0; #1;
        check("rdy_done_idle", mc_valid, 1'b0);

`ifdef MEM_ARB_PERF_EN
        // Fetch grants: single, simultaneous, starvation, post-flush, rdy = 5.
        // Data grants: 1 + 6 + 1 load + 1 store = 9. Forced: 1.
        check("perf_inst",   perf_inst_grants,   32'd5);
        check("perf_data",   perf_data_grants,   32'd9);
        check("perf_forced", perf_starve_forced, 32'd1);
`endif

        // ---------------- reset mid-operation ----------------
        inst_valid = 1'b1; inst_addr = 32'h600;
        step();
        check("rmo_valid", mc_valid, 1'b1);
        rst_in = 1'b1; rob_clear = 1'b1; mc_ready = 1'b1; #1;
        check("rmo_no_abort", mc_abort,   1'b0);
        check("rmo_no_ready", inst_ready, 1'b0);
        step();
        check("rmo_valid_clr", mc_valid, 1'b0);
        check("rmo_addr_clr",  mc_addr,  32'h0);
        check("rmo_len_clr",   mc_len,   3'd0);
`ifdef MEM_ARB_PERF_EN
        check("rmo_perf_clr", perf_inst_grants, 32'd0);
`endif
        rst_in = 1'b0; rob_clear = 1'b0; mc_ready = 1'b0; inst_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
